ysyx_24080006_lsu: RTL
======================

# ysyx_24080006_lsu

Load/store unit directly downstream of the execute-stage ALU: takes the ALU sum as the effective address plus the store operand, issues one transaction on the core's simple data-memory bus, and hands the formatted load result or store completion to write-back. Operation is multi-cycle with valid/ready on both pipeline sides, one transaction in flight, and in-unit misalignment and bus-error detection.

## Interface
- No parameters; data path fixed at 32 bits.
- `clock`  in  1  sole clock.
- `reset_n`  in  1  reset, asynchronous and active-low.
- `in_valid`  in  1  execute stage presents a memory op.
- `in_ready`  out  1  unit can accept.
- `in_addr`  in  32  effective address (ALU add result).
- `in_wdata`  in  32  store operand (rs2).
- `in_op`  in  lsu_op_e  LB, LH, LW, LBU, LHU, SB, SH, SW.
- `in_rd`  in  5  destination register tag, passed through.
- `req_valid` / `req_ready`  out / in  1  bus request handshake.
- `req_we`  out  1  1 = store.
- `req_addr`  out  32  word-aligned address, `{in_addr[31:2], 2'b00}`.
- `req_wdata`  out  32  lane-replicated store data.
- `req_wstrb`  out  4  byte enables; 0 for loads.
- `rsp_valid`  in  1  bus response; always accepted in WAIT.
- `rsp_rdata`  in  32  raw read word.
- `rsp_err`  in  1  access fault.
- `out_valid` / `out_ready`  out / in  1  write-back handshake.
- `out_rdata`  out  32  extended load data; 0 for stores or on exception.
- `out_rd`  out  5  captured `in_rd`.
- `out_wen`  out  1  1 = load completed without exception.
- `out_exc`  out  lsu_exc_e  NONE, MISALIGN, ACCESS.

## Operation
- FSM `IDLE -> REQ -> WAIT -> DONE -> IDLE`; `in_ready = (state == IDLE)`.
- IDLE: on `in_valid`, register addr, wdata, op, rd. Aligned -> REQ. Misaligned -> DONE with `out_exc = MISALIGN` and no bus request. Misaligned means halfword op with `addr[0]=1`, or word op with `addr[1:0]!=0`.
- REQ: hold `req_valid=1` with stable payload until `req_ready`, then go to WAIT.
- WAIT: on `rsp_valid`, capture data, go to DONE. `rsp_err=1` gives `out_exc = ACCESS`, `out_rdata=0`, `out_wen=0`. Store responses carry no data.
- DONE: hold `out_valid=1` with stable payload until `out_ready`, then go to IDLE.
- Store formatting, `o = addr[1:0]`:
  - SB: `wstrb = 4'b0001<<o`, `wdata = {4{b}}`.
  - SH: `wstrb = 4'b0011<<o`, `wdata = {2{h}}`.
  - SW: `wstrb = 4'b1111`.
- Load formatting: `w = rsp_rdata >> (8*o)`. LB and LH sign-extend `w[7:0]` and `w[15:0]`; LBU and LHU zero-extend; LW takes `w` as is.

## Timing
- Reset (async assert, sync deassert): state IDLE; `in_ready` goes to 1 on the first clock edge after deassertion. All other outputs 0: `req_*`, `out_valid`, `out_rdata`, `out_rd`, `out_wen`, `out_exc = NONE`.
- Reset mid-transaction aborts to IDLE. The bus shares `reset_n`, so no stale response can arrive after reset.
- Best-case latency, with `req_ready` and `rsp_valid` each asserted on the first eligible cycle:
  - accept at edge T;
  - `req_valid` high in cycle T+1;
  - response in cycle T+2;
  - `out_valid` in cycle T+3.
- Misaligned ops: `out_valid` is high in the cycle after acceptance.
- `rsp_valid` is only legal in a cycle after the request handshake completed; outside WAIT it is ignored.
- `in_ready` stays 0 from acceptance until the cycle after `out_valid && out_ready`. No back-to-back bypass.
- `out_valid` high with `out_ready` low holds every out_* bit stable indefinitely.

## Structure
- `ysyx_24080006_pkg` gains:
  - `lsu_op_e` (3-bit);
  - `lsu_exc_e` (2-bit: NONE=0, MISALIGN=1, ACCESS=2);
  - `lsu_state_e`.
- One combinational sub-module `ysyx_24080006_lsu_align` holds the misalignment check, wstrb/wdata generation and load extract/extend. The FSM and registers stay in the top.

## Test plan
- **SW** addr `0x8000_0004`, data `0xDEAD_BEEF`, `req_ready` held low 3 cycles:
  - `req_valid` stays high with `req_addr=0x8000_0004`, `wstrb=4'b1111`;
  - then `out_valid` with `out_wen=0`, `out_exc=NONE`.
- **LB / LBU** addr `0x...03`, `rsp_rdata=0x80FF_1234`: `out_rdata=0xFFFF_FF80` for LB and `0x0000_0080` for LBU, `out_wen=1`.
- **SH / LH** addr `0x...02`:
  - SH data `0x0000_ABCD` gives `wstrb=4'b1100`, `wdata=0xABCD_ABCD`;
  - LH with `rsp_rdata=0x8001_0000` gives `out_rdata=0xFFFF_8001`.
- **LW** addr `0x...06`: no `req_valid`; `out_valid` in the cycle after acceptance with `out_exc=MISALIGN`, `out_wen=0`.
- **LW** with `rsp_err=1`: `out_exc=ACCESS`, `out_rdata=0`, `out_rd` equals the accepted `in_rd`.
- **Reset and backpressure**:
  - `reset_n` pulled low in WAIT: all outputs 0 immediately, then `in_ready=1`;
  - `out_ready` held low 5 cycles in DONE: out_* bits stable and `in_ready=0` throughout.

Source files
------------

// File: rtl/ysyx_24080006_pkg.sv
// Shared types for the ysyx_24080006 core: load/store op codes, exception codes and LSU states.
package ysyx_24080006_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [2:0] {
    OP_LB  = 3'd0,
    OP_LH  = 3'd1,
    OP_LW  = 3'd2,
    OP_LBU = 3'd3,
    OP_LHU = 3'd4,
    OP_SB  = 3'd5,
    OP_SH  = 3'd6,
    OP_SW  = 3'd7
  } lsu_op_e;

  typedef enum logic [1:0] {
    EXC_NONE     = 2'd0,
    EXC_MISALIGN = 2'd1,
    EXC_ACCESS   = 2'd2
  } lsu_exc_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } lsu_state_e;

endpackage

// File: rtl/ysyx_24080006_lsu_align.sv
// Combinational byte-lane logic for the LSU: alignment check, store lane
// replication with byte strobes, and load extract with sign/zero extension.
module ysyx_24080006_lsu_align
  import ysyx_24080006_pkg::*;
(
  input  lsu_op_e           op,
  input  logic [1:0]        offset,
  input  logic [DATA_W-1:0] st_data,
  input  logic [DATA_W-1:0] ld_word,
  output logic              misalign,
  output logic              is_store,
  output logic [3:0]        wstrb,
  output logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] ld_data
);

  function automatic logic [DATA_W-1:0] sext8(input logic signed [7:0] b);
    logic signed [DATA_W-1:0] r;
    r = DATA_W'(b);
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] sext16(input logic signed [15:0] h);
    logic signed [DATA_W-1:0] r;
    r = DATA_W'(h);
    return r;
  endfunction

  logic [DATA_W-1:0] word;

  always_comb begin
    misalign = 1'b0;
    is_store = 1'b0;
    wstrb    = 4'b0000;
    wdata    = '0;
    ld_data  = '0;
    word     = ld_word >> {offset, 3'b000};

    case (op)
      OP_LH, OP_LHU, OP_SH: misalign = offset[0];
      OP_LW, OP_SW:         misalign = |offset;
      default:              misalign = 1'b0;
    endcase

    case (op)
      OP_SB: begin
        is_store = 1'b1;
        wstrb    = 4'b0001 << offset;
        wdata    = {4{st_data[7:0]}};
      end
      OP_SH: begin
        is_store = 1'b1;
        wstrb    = 4'b0011 << offset;
        wdata    = {2{st_data[15:0]}};
      end
      OP_SW: begin
        is_store = 1'b1;
        wstrb    = 4'b1111;
        wdata    = st_data;
      end
      OP_LB:   ld_data = sext8(word[7:0]);
      OP_LH:   ld_data = sext16(word[15:0]);
      OP_LBU:  ld_data = {24'b0, word[7:0]};
      OP_LHU:  ld_data = {16'b0, word[15:0]};
      OP_LW:   ld_data = word;
      default: ld_data = '0;
    endcase
  end

endmodule

// File: rtl/ysyx_24080006_lsu.sv
// Load/store unit: one data-memory transaction in flight, valid/ready on both
// pipeline sides, misalignment and bus-error reporting to write-back.
module ysyx_24080006_lsu
  import ysyx_24080006_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_wdata,
  input  lsu_op_e           in_op,
  input  logic [4:0]        in_rd,
  output logic              req_valid,
  input  logic              req_ready,
  output logic              req_we,
  output logic [DATA_W-1:0] req_addr,
  output logic [DATA_W-1:0] req_wdata,
  output logic [3:0]        req_wstrb,
  input  logic              rsp_valid,
  input  logic [DATA_W-1:0] rsp_rdata,
  input  logic              rsp_err,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_rdata,
  output logic [4:0]        out_rd,
  output logic              out_wen,
  output lsu_exc_e          out_exc
);

  lsu_state_e state_q, state_d;
  logic       rdy_en;

  logic [DATA_W-1:0] addr_p0, wdata_p0;
  lsu_op_e           op_p0;
  logic [4:0]        rd_p0;
  logic [DATA_W-1:0] rdata_p1;
  logic              wen_p1;
  lsu_exc_e          exc_p1;

  lsu_op_e           op_sel;
  logic [1:0]        off_sel;
  logic              misalign, is_store;
  logic [3:0]        fmt_wstrb;
  logic [DATA_W-1:0] fmt_wdata, fmt_ldata;
  logic              accept;

  // In IDLE the alignment check must see the incoming op; afterwards the captured one.
  assign op_sel  = (state_q == ST_IDLE) ? in_op : op_p0;
  assign off_sel = (state_q == ST_IDLE) ? in_addr[1:0] : addr_p0[1:0];

  ysyx_24080006_lsu_align u_align (
    .op       (op_sel),
    .offset   (off_sel),
    .st_data  (wdata_p0),
    .ld_word  (rsp_rdata),
    .misalign (misalign),
    .is_store (is_store),
    .wstrb    (fmt_wstrb),
    .wdata    (fmt_wdata),
    .ld_data  (fmt_ldata)
  );

  // rdy_en keeps in_ready low until the first edge after reset releases.
  assign in_ready = rdy_en && (state_q == ST_IDLE);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      rdy_en  <= 1'b0;
    end else begin
      state_q <= state_d;
      rdy_en  <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept)    state_d = misalign ? ST_DONE : ST_REQ;
      ST_REQ:  if (req_ready) state_d = ST_WAIT;
      ST_WAIT: if (rsp_valid) state_d = ST_DONE;
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  // Stage p0: operands captured at acceptance.
  always_ff @(posedge clock) begin
    if (accept) begin
      addr_p0  <= in_addr;
      wdata_p0 <= in_wdata;
      op_p0    <= in_op;
      rd_p0    <= in_rd;
    end
  end

  // Stage p1: write-back result, from the alignment check or the bus response.
  always_ff @(posedge clock) begin
    if (accept) begin
      rdata_p1 <= '0;
      wen_p1   <= 1'b0;
      exc_p1   <= misalign ? EXC_MISALIGN : EXC_NONE;
    end else if ((state_q == ST_WAIT) && rsp_valid) begin
      rdata_p1 <= (rsp_err || is_store) ? '0 : fmt_ldata;
      wen_p1   <= !rsp_err && !is_store;
      exc_p1   <= rsp_err ? EXC_ACCESS : EXC_NONE;
    end
  end

  // Payloads are gated by state so every output reads zero outside its phase.
  always_comb begin
    req_valid = (state_q == ST_REQ);
    req_we    = req_valid && is_store;
    req_addr  = req_valid ? {addr_p0[31:2], 2'b00} : '0;
    req_wdata = req_valid ? fmt_wdata : '0;
    req_wstrb = req_valid ? fmt_wstrb : 4'b0000;
    out_valid = (state_q == ST_DONE);
    out_rdata = out_valid ? rdata_p1 : '0;
    out_rd    = out_valid ? rd_p0 : 5'd0;
    out_wen   = out_valid && wen_p1;
    out_exc   = out_valid ? exc_p1 : EXC_NONE;
  end

endmodule
